qspi_psram: RTL and testbench

QSPI_PSRAM -- requirements
Module: qspi_psram

---
 rtl/qspi_psram_pkg.sv | 22 ++
 rtl/qspi_psram_sync.sv | 39 +++
 rtl/qspi_psram.sv | 173 +++++++++++++++++
 tb/tb_qspi_psram.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/qspi_psram_pkg.sv
// rtl/qspi_psram_pkg.sv - opcodes, protocol lengths and FSM states for the QSPI PSRAM model
package qspi_psram_pkg;

  localparam logic [7:0] OP_QREAD     = 8'hEB;
  localparam logic [7:0] OP_QWRITE    = 8'h38;
  localparam logic [7:0] OP_QPI_ENTER = 8'h35;
  localparam logic [7:0] OP_QPI_EXIT  = 8'hF5;

  localparam int DUMMY_CYCLES = 6;
  localparam int ADDR_NIBBLES = 6;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    RDATA,
    WDATA,
    IGNORE
  } state_e;

endpackage

// File: rtl/qspi_psram_sync.sv
// rtl/qspi_psram_sync.sv - 2-flop synchronizers for the SPI pins and sck edge detection
module qspi_psram_sync (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sck_i,
  input  logic       cs_in,
  input  logic [3:0] io_i,
  output logic       cs_n_o,
  output logic [3:0] io_o,
  output logic       sck_rise_o,
  output logic       sck_fall_o
);

  logic [2:0] sck_q;
  logic [1:0] cs_q;
  logic [3:0] io1_q;
  logic [3:0] io2_q;

  // cs resets to 0 so a chip select still held low after reset never looks like a new falling edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_q <= '0;
      cs_q  <= '0;
      io1_q <= '0;
      io2_q <= '0;
    end else begin
      sck_q <= {sck_q[1:0], sck_i};
      cs_q  <= {cs_q[0], cs_in};
      io1_q <= io_i;
      io2_q <= io1_q;
    end
  end

  assign cs_n_o     = cs_q[1];
  assign io_o       = io2_q;
  assign sck_rise_o = sck_q[1] & ~sck_q[2];
  assign sck_fall_o = ~sck_q[1] & sck_q[2];

endmodule

// File: rtl/qspi_psram.sv
// rtl/qspi_psram.sv - QSPI PSRAM slave (0xEB quad read, 0x38 quad write), oversampled on clk_i
// Optional QPI opcode mode (0x35 enter, 0xF5 exit) when QSPI_PSRAM_QPI_EN is defined.
module qspi_psram
  import qspi_psram_pkg::*;
#(
  parameter int DEPTH = 16777216
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sck_i,
  input  logic cs_in,
  inout  wire  io0_io,
  inout  wire  io1_io,
  inout  wire  io2_io,
  inout  wire  io3_io
);

  localparam int AW = $clog2(DEPTH);

  logic          cs_n, sck_rise, sck_fall;
  logic [3:0]    io_s;
  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [19:0]   shift_q, shift_d;
  logic [7:0]    op_q, op_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [3:0]    hi_q, hi_d;
  logic          phase_q, phase_d;
  logic [3:0]    dout_q, dout_d;
  logic          oe_q, oe_d;
  logic          qpi_q, qpi_d;
  logic          cs_prev_q;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    rd_byte, wdata, op_next;
  logic [23:0]   addr_next;
  logic [2:0]    cmd_last;
  logic          we;

  qspi_psram_sync u_sync (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .sck_i      (sck_i),
    .cs_in      (cs_in),
    .io_i       ({io3_io, io2_io, io1_io, io0_io}),
    .cs_n_o     (cs_n),
    .io_o       (io_s),
    .sck_rise_o (sck_rise),
    .sck_fall_o (sck_fall)
  );

  assign rd_byte   = mem_q[idx_q];
  assign wdata     = {hi_q, io_s};
  assign addr_next = {shift_q, io_s};
  assign op_next   = qpi_q ? {shift_q[3:0], io_s} : {shift_q[6:0], io_s[0]};
  assign cmd_last  = qpi_q ? 3'd1 : 3'd7;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    op_d    = op_q;
    idx_d   = idx_q;
    hi_d    = hi_q;
    phase_d = phase_q;
    dout_d  = dout_q;
    oe_d    = oe_q;
    qpi_d   = qpi_q;
    we      = 1'b0;
    if (cs_n) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (cs_prev_q) begin
          state_d = CMD;
          cnt_d   = '0;
          shift_d = '0;
          phase_d = 1'b0;
        end
        CMD: if (sck_rise) begin
          shift_d = qpi_q ? {shift_q[15:0], io_s} : {shift_q[18:0], io_s[0]};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == cmd_last) begin
            cnt_d   = '0;
            op_d    = op_next;
            state_d = (op_next == OP_QREAD || op_next == OP_QWRITE) ? ADDR : IGNORE;
`ifdef QSPI_PSRAM_QPI_EN
            if (op_next == OP_QPI_ENTER) qpi_d = 1'b1;
            if (op_next == OP_QPI_EXIT)  qpi_d = 1'b0;
`endif
          end
        end
        ADDR: if (sck_rise) begin
          shift_d = {shift_q[15:0], io_s};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'(ADDR_NIBBLES - 1)) begin
            cnt_d   = '0;
            idx_d   = AW'(addr_next);
            phase_d = 1'b0;
            state_d = (op_q == OP_QREAD) ? DUMMY : WDATA;
          end
        end
        DUMMY: if (sck_rise) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'(DUMMY_CYCLES - 1)) begin
            cnt_d   = '0;
            state_d = RDATA;
          end
        end
        RDATA: if (sck_fall) begin
          oe_d    = 1'b1;
          phase_d = ~phase_q;
          if (!phase_q) begin
            dout_d = rd_byte[7:4];
          end else begin
            dout_d = rd_byte[3:0];
            idx_d  = idx_q + 1'b1;
          end
        end
        WDATA: if (sck_rise) begin
          phase_d = ~phase_q;
          if (!phase_q) begin
            hi_d = io_s;
          end else begin
            we    = 1'b1;
            idx_d = idx_q + 1'b1;
          end
        end
        IGNORE: ;
        default: state_d = IDLE;
      endcase
    end
    // the bus is released the moment the FSM leaves RDATA for any reason
    if (state_d != RDATA) oe_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      op_q      <= '0;
      idx_q     <= '0;
      hi_q      <= '0;
      phase_q   <= 1'b0;
      dout_q    <= '0;
      oe_q      <= 1'b0;
      qpi_q     <= 1'b0;
      cs_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      hi_q      <= hi_d;
      phase_q   <= phase_d;
      dout_q    <= dout_d;
      oe_q      <= oe_d;
      qpi_q     <= qpi_d;
      cs_prev_q <= cs_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we && !rst_i) mem_q[idx_q] <= wdata;
  end

  assign io0_io = oe_q ? dout_q[0] : 1'bz;
  assign io1_io = oe_q ? dout_q[1] : 1'bz;
  assign io2_io = oe_q ? dout_q[2] : 1'bz;
  assign io3_io = oe_q ? dout_q[3] : 1'bz;

endmodule

// File: tb/tb_qspi_psram.sv
// tb/tb_qspi_psram.sv - scoreboard bench for qspi_psram; undriven io lines read 1 through pullups
module tb_qspi_psram;

  localparam int DEPTH = 4096;
  localparam int HALF  = 60;

  logic       clk = 1'b0;
  logic       rst;
  logic       sck;
  logic       cs_n;
  logic [3:0] h_dout;
  logic       h_oe;
  wire        io0, io1, io2, io3;
  wire  [3:0] io_bus = {io3, io2, io1, io0};

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];

  assign io0 = h_oe ? h_dout[0] : 1'bz;
  assign io1 = h_oe ? h_dout[1] : 1'bz;
  assign io2 = h_oe ? h_dout[2] : 1'bz;
  assign io3 = h_oe ? h_dout[3] : 1'bz;
  pullup (io0);
  pullup (io1);
  pullup (io2);
  pullup (io3);

  always #5 clk = ~clk;

  qspi_psram #(.DEPTH(DEPTH)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .sck_i  (sck),
    .cs_in  (cs_n),
    .io0_io (io0),
    .io1_io (io1),
    .io2_io (io2),
    .io3_io (io3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic put_nib(input logic [3:0] n);
    h_oe   = 1'b1;
    h_dout = n;
    #HALF sck = 1'b1;
    #HALF sck = 1'b0;
  endtask

  task automatic begin_txn();
    cs_n = 1'b0;
    #20;
  endtask

  task automatic end_txn();
    h_oe = 1'b0;
    #HALF cs_n = 1'b1;
    #300;
  endtask

  task automatic send_op(input logic [7:0] op, input bit qpi);
    if (qpi) begin
      put_nib(op[7:4]);
      put_nib(op[3:0]);
    end else begin
      for (int i = 7; i >= 0; i--) put_nib({3'b000, op[i]});
    end
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) put_nib(a[i*4 +: 4]);
  endtask

  task automatic write_txn(input logic [23:0] a, input logic [31:0] data, input int n);
    begin_txn();
    send_op(8'h38, 1'b0);
    send_addr(a);
    for (int i = n - 1; i >= 0; i--) begin
      put_nib(data[i*8+4 +: 4]);
      put_nib(data[i*8 +: 4]);
    end
    end_txn();
  endtask

  task automatic dummy_cycles();
    h_oe = 1'b0;
    repeat (6) begin
      #HALF sck = 1'b1;
      #HALF sck = 1'b0;
    end
  endtask

  task automatic read_txn(input logic [23:0] a, input int n, input bit qpi, input string tag);
    logic [3:0] hi, lo;
    begin_txn();
    send_op(8'hEB, qpi);
    send_addr(a);
    dummy_cycles();
    for (int i = 0; i < n; i++) begin
      #HALF hi = io_bus;
      sck = 1'b1;
      #HALF sck = 1'b0;
      #HALF lo = io_bus;
      sck = 1'b1;
      #HALF sck = 1'b0;
      if (exp_q.size() == 0) check({tag, "_sb_empty"}, 1, 0);
      else check(tag, {hi, lo}, exp_q.pop_front());
    end
    end_txn();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst    = 1'b1;
    cs_n   = 1'b1;
    sck    = 1'b0;
    h_oe   = 1'b0;
    h_dout = 4'h0;
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #100;
    check("reset_hiz", io_bus, 4'hF);

    write_txn(24'h000010, 32'hDEADBEEF, 4);
    exp_q.push_back(8'hDE); exp_q.push_back(8'hAD);
    exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
    read_txn(24'h000010, 4, 1'b0, "rd_deadbeef");
    exp_q.push_back(8'hAD);
    read_txn(24'(DEPTH + 'h11), 1, 1'b0, "rd_addr_mod");

    write_txn(24'(DEPTH - 1), 32'h00001122, 2);
    exp_q.push_back(8'h22);
    read_txn(24'h000000, 1, 1'b0, "rd_wrap_0");
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    read_txn(24'(DEPTH - 1), 2, 1'b0, "rd_wrap_top");

    begin_txn();
    send_op(8'h9F, 1'b0);
    h_oe = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #HALF check("unk_op_hiz_lo", io_bus, 4'hF);
      sck = 1'b1;
      #HALF check("unk_op_hiz_hi", io_bus, 4'hF);
      sck = 1'b0;
    end
    end_txn();

    write_txn(24'h000020, 32'h0000005A, 3);
    begin_txn();
    send_op(8'h38, 1'b0);
    send_addr(24'h000020);
    put_nib(4'hA); put_nib(4'hA);
    put_nib(4'hB); put_nib(4'hB);
    put_nib(4'hC);
    end_txn();
    exp_q.push_back(8'hAA); exp_q.push_back(8'hBB); exp_q.push_back(8'h5A);
    read_txn(24'h000020, 3, 1'b0, "rd_partial");

    write_txn(24'h000040, 32'h00001234, 2);
    begin_txn();
    send_op(8'hEB, 1'b0);
    send_addr(24'h000040);
    dummy_cycles();
    #HALF check("rd_before_rst", io_bus, 4'h1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1 check("rst_release", io_bus, 4'hF);
    rst = 1'b0;
    end_txn();
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    read_txn(24'h000040, 2, 1'b0, "rd_after_rst");

    write_txn(24'h000060, 32'h0000005C, 1);
    begin_txn();
    send_op(8'h35, 1'b0);
    end_txn();
`ifdef QSPI_PSRAM_QPI_EN
    exp_q.push_back(8'h5C);
    read_txn(24'h000060, 1, 1'b1, "rd_qpi");
    begin_txn();
    send_op(8'hF5, 1'b1);
    end_txn();
    exp_q.push_back(8'h5C);
    read_txn(24'h000060, 1, 1'b0, "rd_after_qpi_exit");
`else
    exp_q.push_back(8'h5C);
    read_txn(24'h000060, 1, 1'b0, "rd_after_35_serial");
    begin_txn();
    send_op(8'hF5, 1'b0);
    end_txn();
    exp_q.push_back(8'h5C);
    read_txn(24'h000060, 1, 1'b0, "rd_after_f5_serial");
`endif

    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
